// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and round-robin helper for the UART TX arbiter
package uart_pkg;

   localparam int         UART_BYTE_W = 8;
   localparam int         MAX_REQ     = 8;
   localparam logic [3:0] HDR_TAG     = 4'hA;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD1 = 3'd1,
      LOAD2 = 3'd2,
      SEND  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5,
      ABORT = 3'd6
   } tx_arb_state_t;

   // First set request strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 num_req);
      logic [2:0] pick;
      int         idx;
      pick = ptr;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= num_req) begin
            idx = (int'(ptr) + k) % num_req;
            if (req[3'(idx)]) pick = 3'(idx);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick returning one-hot grant and channel id
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [2:0]         gnt_id,
   output logic               gnt_vld
);

   logic [MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext = '0;
      req_ext[NUM_REQ-1:0] = req;
      gnt_vld = |req;
      gnt_id  = rr_pick(req_ext, ptr, NUM_REQ);
      gnt     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = gnt_vld && (gnt_id == 3'(i));
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART byte engine among requesters, optional id header
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WORD_BYTES = 2,
   parameter int HEADER_EN  = 1,
   parameter int TIMEOUT    = 15
) (
   input  logic                                      txclk,
   input  logic                                      reset,
   input  logic [NUM_REQ-1:0]                        req,
   input  logic [NUM_REQ*WORD_BYTES*UART_BYTE_W-1:0] req_data,
   output logic [NUM_REQ-1:0]                        ack,
   output logic                                      busy,
   output logic [2:0]                                grant_id,
   output logic                                      err,
   output logic                                      eng_ld,
   output logic                                      eng_en,
   output logic [UART_BYTE_W-1:0]                    eng_data,
   input  logic                                      eng_empty
);

   localparam int WORD_W = WORD_BYTES * UART_BYTE_W;
   localparam int TOTAL  = WORD_BYTES + ((HEADER_EN != 0) ? 1 : 0);
   localparam int CNT_W  = 5;
   localparam int TOUT_W = $clog2(TIMEOUT + 1);

   tx_arb_state_t           state_q, state_d;
   logic [WORD_W-1:0]       shift_q, shift_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic [TOUT_W-1:0]       tout_cnt_q, tout_cnt_d;
   logic [2:0]              rr_ptr_q, rr_ptr_d;
   logic [2:0]              grant_id_q, grant_id_d;
   logic                    busy_q, busy_d;
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    eng_ld_q, eng_ld_d;
   logic [UART_BYTE_W-1:0]  eng_data_q, eng_data_d;

   logic [NUM_REQ-1:0]      arb_gnt;
   logic [2:0]              arb_id;
   logic                    arb_vld;
   logic [WORD_W-1:0]       arb_word;
   logic                    is_hdr;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req     (req),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_id  (arb_id),
      .gnt_vld (arb_vld)
   );

   always_comb begin
      arb_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) arb_word = req_data[i*WORD_W +: WORD_W];
      end
   end

   assign is_hdr = (HEADER_EN != 0) && (byte_cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      tout_cnt_d = tout_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               shift_d    = arb_word;
               grant_id_d = arb_id;
               byte_cnt_d = '0;
               tout_cnt_d = '0;
               state_d    = LOAD1;
            end
         end
         LOAD1: state_d = LOAD2;
         LOAD2: state_d = SEND;
         SEND: begin
            tout_cnt_d = tout_cnt_q + TOUT_W'(1);
            if (eng_empty) state_d = NEXT;
            else if (tout_cnt_d == TOUT_W'(TIMEOUT)) state_d = ABORT;
         end
         NEXT: begin
            tout_cnt_d = '0;
            if (!is_hdr) shift_d = shift_q << UART_BYTE_W;
            if (byte_cnt_q == CNT_W'(TOTAL - 1)) begin
               state_d = DONE;
            end else begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               state_d    = LOAD1;
            end
         end
         DONE: begin
            rr_ptr_d = grant_id_q;
            state_d  = IDLE;
         end
         ABORT: begin
            rr_ptr_d = grant_id_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the engine handshake never glitches.
   always_comb begin
      eng_ld_d   = (state_d != SEND);
      busy_d     = (state_d != IDLE);
      err_d      = (state_d == ABORT);
      eng_data_d = eng_data_q;
      ack_d      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack_d[i] = (state_d == DONE) && (grant_id_q == 3'(i));
      end
      if (state_d == LOAD1) begin
         if ((HEADER_EN != 0) && (byte_cnt_d == '0)) eng_data_d = {HDR_TAG, 1'b0, grant_id_d};
         else eng_data_d = shift_d[WORD_W-1 -: UART_BYTE_W];
      end
   end

   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         tout_cnt_q <= '0;
         rr_ptr_q   <= 3'(NUM_REQ - 1);
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         eng_ld_q   <= 1'b1;
         eng_data_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         tout_cnt_q <= tout_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         eng_ld_q   <= eng_ld_d;
         eng_data_q <= eng_data_d;
      end
   end

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign grant_id = grant_id_q;
   assign err      = err_q;
   assign eng_ld   = eng_ld_q;
   assign eng_en   = ~eng_ld_q;
   assign eng_data = eng_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench with byte-engine model and serial line decoder
module tb_uart_tx_arbiter;

   logic        txclk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic [3:0]  req0  = '0;
   logic [1:0]  req1  = '0;
   logic [63:0] rd0   = '0;
   logic [15:0] rd1   = '0;
   logic [3:0]  ack0;
   logic [1:0]  ack1;
   logic        busy0, busy1, err0, err1;
   logic [2:0]  gid0, gid1;
   logic [1:0]  e_ld, e_en, e_empty, e_tx;
   logic [7:0]  e_data [2];
   logic [7:0]  e_sh [2];
   logic [3:0]  e_cnt [2];
   int          d_st [2];
   logic [7:0]  d_sh [2];
   logic [8:0]  rx0_q [$];
   logic [8:0]  rx1_q [$];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          k, base;
   logic [7:0]  exp2 [12];

   always #5 txclk = ~txclk;
   always @(posedge txclk) cyc <= cyc + 1;

   uart_tx_arbiter #(.NUM_REQ(4), .WORD_BYTES(2), .HEADER_EN(1), .TIMEOUT(15)) u_dut0 (
      .txclk(txclk), .reset(reset), .req(req0), .req_data(rd0), .ack(ack0), .busy(busy0),
      .grant_id(gid0), .err(err0), .eng_ld(e_ld[0]), .eng_en(e_en[0]), .eng_data(e_data[0]),
      .eng_empty(e_empty[0] & ~stall)
   );

   uart_tx_arbiter #(.NUM_REQ(2), .WORD_BYTES(1), .HEADER_EN(0), .TIMEOUT(15)) u_dut1 (
      .txclk(txclk), .reset(reset), .req(req1), .req_data(rd1), .ack(ack1), .busy(busy1),
      .grant_id(gid1), .err(err1), .eng_ld(e_ld[1]), .eng_en(e_en[1]), .eng_data(e_data[1]),
      .eng_empty(e_empty[1])
   );

   // Byte engine: one line bit per txclk; empty rises with the stop bit.
   always @(posedge txclk or posedge reset) begin
      for (int e = 0; e < 2; e++) begin
         if (reset) begin
            e_empty[e] <= 1'b1;
            e_tx[e]    <= 1'b1;
            e_cnt[e]   <= '0;
            e_sh[e]    <= '0;
         end else if (e_ld[e]) begin
            e_sh[e]    <= e_data[e];
            e_empty[e] <= 1'b0;
            e_cnt[e]   <= '0;
         end else if (e_en[e] && !e_empty[e]) begin
            e_cnt[e] <= e_cnt[e] + 4'd1;
            if (e_cnt[e] == 4'd0) e_tx[e] <= 1'b0;
            else if (e_cnt[e] <= 4'd8) e_tx[e] <= e_sh[e][3'(e_cnt[e] - 4'd1)];
            else begin
               e_tx[e]    <= 1'b1;
               e_empty[e] <= 1'b1;
            end
         end
      end
   end

   always @(negedge txclk) begin
      for (int e = 0; e < 2; e++) begin
         if (reset) d_st[e] <= 0;
         else if (d_st[e] == 0) begin
            if (!e_tx[e]) d_st[e] <= 1;
         end else if (d_st[e] <= 8) begin
            d_sh[e] <= {e_tx[e], d_sh[e][7:1]};
            d_st[e] <= d_st[e] + 1;
         end else begin
            if (e == 0) rx0_q.push_back({e_tx[e], d_sh[e]});
            else rx1_q.push_back({e_tx[e], d_sh[e]});
            d_st[e] <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge txclk);
         #2;
      end
   endtask

   task automatic check_byte(input string tag, input bit sel, input int idx, input logic [7:0] exp);
      logic [8:0] got;
      got = 9'h0;
      if (!sel && idx < rx0_q.size()) got = rx0_q[idx];
      if (sel && idx < rx1_q.size()) got = rx1_q[idx];
      check(tag, 32'(got), 32'({1'b1, exp}));
   endtask

   task automatic wait_evt(input string tag, input bit sel, input int budget);
      int t;
      t = 0;
      while (((!sel && ack0 == '0 && !err0) || (sel && ack1 == '0)) && t < budget) begin
         step(1);
         t++;
      end
      check(tag, 32'(sel ? (ack1 != '0) : (ack0 != '0 || err0)), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0  = '0;
      req1  = '0;
      stall = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      exp2 = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04, 8'hA3, 8'h07, 8'h08, 8'hA0, 8'h01, 8'h02};

      // reset values
      #1 reset = 1'b1;
      #1;
      check("rst_eng_ld", 32'(e_ld[0]), 32'd1);
      check("rst_eng_en", 32'(e_en[0]), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_ack", 32'(ack0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_gid", 32'(gid0), 32'd0);
      check("rst_eng_data", 32'(e_data[0]), 32'd0);
      check("rst_eng_ld1", 32'(e_ld[1]), 32'd1);

      // single request with header
      do_reset();
      rd0[32 +: 16] = 16'hBEEF;
      req0 = 4'b0100;
      k = cyc;
      base = rx0_q.size();
      wait_evt("t1_ack_seen", 1'b0, 80);
      req0 = '0;
      check("t1_ack_val", 32'(ack0), 32'h4);
      check("t1_latency", 32'(cyc - k), 32'd43);
      check("t1_gid", 32'(gid0), 32'd2);
      check("t1_nbytes", 32'(rx0_q.size() - base), 32'd3);
      check_byte("t1_b0", 1'b0, base, 8'hA2);
      check_byte("t1_b1", 1'b0, base + 1, 8'hBE);
      check_byte("t1_b2", 1'b0, base + 2, 8'hEF);
      step(1);
      check("t1_ack_1cyc", 32'(ack0), 32'd0);
      step(5);
      check("t1_no_regrant", 32'(busy0), 32'd0);

      // contention, round-robin order 0,1,3,0
      do_reset();
      rd0 = 64'h0708_0506_0304_0102;
      req0 = 4'b1011;
      k = cyc;
      base = rx0_q.size();
      for (int w = 0; w < 4; w++) begin
         wait_evt("t2_ack_seen", 1'b0, 80);
         check("t2_ack_val", 32'(ack0), (w == 0 || w == 3) ? 32'h1 : (w == 1) ? 32'h2 : 32'h8);
         check("t2_spacing", 32'(cyc - k), (w == 0) ? 32'd43 : 32'd44);
         k = cyc;
         step(1);
         check("t2_ack_1cyc", 32'(ack0), 32'd0);
         check("t2_busy_gap", 32'(busy0), 32'd0);
         step(1);
         check("t2_busy_back", 32'(busy0), 32'd1);
      end
      for (int i = 0; i < 12; i++) check_byte("t2_byte", 1'b0, base + i, exp2[i]);

      // payload-only, single byte
      do_reset();
      rd1 = {8'h00, 8'h55};
      req1 = 2'b01;
      k = cyc;
      base = rx1_q.size();
      wait_evt("t3_ack_seen", 1'b1, 40);
      req1 = '0;
      check("t3_ack_val", 32'(ack1), 32'h1);
      check("t3_latency", 32'(cyc - k), 32'd15);
      check("t3_nbytes", 32'(rx1_q.size() - base), 32'd1);
      check_byte("t3_b0", 1'b1, base, 8'h55);

      // engine timeout, then normal service of the next request
      do_reset();
      stall = 1'b1;
      rd0 = 64'h1357_0000_CAFE_0000;
      req0 = 4'b0010;
      k = cyc;
      wait_evt("t4_err_seen", 1'b0, 60);
      check("t4_err", 32'(err0), 32'd1);
      check("t4_err_time", 32'(cyc - k), 32'd18);
      check("t4_no_ack", 32'(ack0), 32'd0);
      stall = 1'b0;
      req0 = 4'b1001;
      step(1);
      check("t4_err_1cyc", 32'(err0), 32'd0);
      check("t4_idle", 32'(busy0), 32'd0);
      k = cyc;
      base = rx0_q.size();
      wait_evt("t4_ack_seen", 1'b0, 80);
      req0 = '0;
      check("t4_rr_after_abort", 32'(ack0), 32'h8);
      check("t4_latency", 32'(cyc - k), 32'd43);
      check_byte("t4_b0", 1'b0, base, 8'hA3);
      check_byte("t4_b1", 1'b0, base + 1, 8'h13);
      check_byte("t4_b2", 1'b0, base + 2, 8'h57);

      // reset during the second payload byte
      do_reset();
      rd0 = 64'h0000_0000_1234_0000;
      req0 = 4'b0010;
      step(33);
      check("t5_mid_busy", 32'(busy0), 32'd1);
      check("t5_mid_send", 32'(e_ld[0]), 32'd0);
      reset = 1'b1;
      #1;
      check("t5_rst_eng_ld", 32'(e_ld[0]), 32'd1);
      check("t5_rst_eng_en", 32'(e_en[0]), 32'd0);
      check("t5_rst_busy", 32'(busy0), 32'd0);
      check("t5_rst_tx", 32'(e_tx[0]), 32'd1);
      check("t5_rst_gid", 32'(gid0), 32'd0);
      check("t5_rst_data", 32'(e_data[0]), 32'd0);
      step(2);
      reset = 1'b0;
      k = cyc;
      base = rx0_q.size();
      wait_evt("t5_ack_seen", 1'b0, 80);
      req0 = '0;
      check("t5_ack_val", 32'(ack0), 32'h2);
      check("t5_latency", 32'(cyc - k), 32'd43);
      check_byte("t5_b0", 1'b0, base, 8'hA1);
      check_byte("t5_b1", 1'b0, base + 1, 8'h12);
      check_byte("t5_b2", 1'b0, base + 2, 8'h34);

      // word latched at grant; req dropped mid-word
      do_reset();
      rd0[32 +: 16] = 16'hABCD;
      req0 = 4'b0100;
      k = cyc;
      base = rx0_q.size();
      step(5);
      rd0[32 +: 16] = 16'h0000;
      req0 = '0;
      wait_evt("t6_ack_seen", 1'b0, 80);
      check("t6_ack_val", 32'(ack0), 32'h4);
      check("t6_latency", 32'(cyc - k), 32'd43);
      check_byte("t6_b0", 1'b0, base, 8'hA2);
      check_byte("t6_b1", 1'b0, base + 1, 8'hAB);
      check_byte("t6_b2", 1'b0, base + 2, 8'hCD);
      step(10);
      check("t6_no_regrant", 32'(busy0), 32'd0);
      check("t6_eng_idle", 32'(e_ld[0]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
